// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the decode stage: opcode class codes, the
// decoded control word, and helpers that pull fields out of an instruction.
package cpu_isa_pkg;

    // Opcode classes, taken from the top three opcode bits
    localparam logic [2:0] CLS_ALU  = 3'b000;
    localparam logic [2:0] CLS_ALUI = 3'b100;
    localparam logic [2:0] CLS_LD   = 3'b001;
    localparam logic [2:0] CLS_ST   = 3'b010;
    localparam logic [2:0] CLS_BR   = 3'b110;
    localparam logic [2:0] CLS_JMP  = 3'b111;

    // Widest op_select any build may use, and the number of one-bit controls
    localparam int OPSEL_MAX_W   = 8;
    localparam int NUM_CTRL_BITS = 7;

    typedef struct packed {
        logic                   mb;
        logic                   rw;
        logic                   md;
        logic                   mw;
        logic                   pl;
        logic                   jb;
        logic                   bc;
        logic [OPSEL_MAX_W-1:0] op_select;
    } ctrl_word_t;

    // Instruction layout is {opcode, rd, rsA, rsB}, MSB first
    function automatic logic [31:0] fld_opcode(input logic [31:0] word, input int ra_w);
        return word >> (3 * ra_w);
    endfunction

    function automatic logic [31:0] fld_rd(input logic [31:0] word, input int ra_w);
        return (word >> (2 * ra_w)) & ((32'd1 << ra_w) - 32'd1);
    endfunction

    function automatic logic [31:0] fld_rsa(input logic [31:0] word, input int ra_w);
        return (word >> ra_w) & ((32'd1 << ra_w) - 32'd1);
    endfunction

    function automatic logic [31:0] fld_rsb(input logic [31:0] word, input int ra_w);
        return word & ((32'd1 << ra_w) - 32'd1);
    endfunction

    // Classes 011 and 101 are unassigned
    function automatic logic is_illegal_cls(input logic [2:0] cls);
        return (cls == 3'b011) || (cls == 3'b101);
    endfunction

endpackage

// File: rtl/dec_ctrl_lut.sv
// Combinational opcode -> control word lookup. Unassigned classes decode to
// a NOP (all one-bit controls low); op_select always mirrors the low opcode bits.
module dec_ctrl_lut
    import cpu_isa_pkg::*;
#(
    parameter int OPC_W   = 7,
    parameter int OPSEL_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    output ctrl_word_t       ctrl
);

    logic [2:0] cls_s;

    assign cls_s = opcode[OPC_W-1 -: 3];

    // Class decode into the one-bit controls plus the ALU operation
    always_comb begin
        ctrl           = '0;
        ctrl.op_select = OPSEL_MAX_W'(opcode[OPSEL_W-1:0]);
        case (cls_s)
            CLS_ALU: begin
                ctrl.rw = 1'b1;
            end
            CLS_ALUI: begin
                ctrl.rw = 1'b1;
                ctrl.mb = 1'b1;
            end
            CLS_LD: begin
                ctrl.rw = 1'b1;
                ctrl.md = 1'b1;
            end
            CLS_ST: begin
                ctrl.mw = 1'b1;
            end
            CLS_BR: begin
                ctrl.pl = 1'b1;
                ctrl.bc = opcode[0];
            end
            CLS_JMP: begin
                ctrl.pl = 1'b1;
                ctrl.jb = 1'b1;
            end
            default: begin
                ctrl.rw = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_dec_stage.sv
// Registered decode stage between fetch and datapath.
// Instructions are decoded on the input side and held in a 2-entry FIFO skid
// buffer whose head entry drives the outputs directly (kept all-zero when empty).
// An instruction that reads the destination of the load accepted just before
// it is parked for one cycle in a staging register, producing one bubble.
// Optional feature macro: DEC_ILLEGAL_TRAP_EN adds the `illegal` output and a
// sticky trap that blocks input until flush or reset.
module instr_dec_stage
    import cpu_isa_pkg::*;
#(
    parameter int RA_W    = 3,
    parameter int OPC_W   = 7,
    parameter int OPSEL_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPC_W+3*RA_W-1:0]   instr,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      MB,
    output logic                      RW,
    output logic                      MD,
    output logic                      MW,
    output logic                      PL,
    output logic                      JB,
    output logic                      BC,
    output logic [OPSEL_W-1:0]        op_select,
    output logic [RA_W-1:0]           rd,
    output logic [RA_W-1:0]           rsA,
`ifdef DEC_ILLEGAL_TRAP_EN
    output logic [RA_W-1:0]           rsB,
    output logic                      illegal
`else
    output logic [RA_W-1:0]           rsB
`endif
);

    localparam int INSTR_W = OPC_W + 3 * RA_W;
`ifdef DEC_ILLEGAL_TRAP_EN
    localparam int ILL_W = 1;
`else
    localparam int ILL_W = 0;
`endif
    // Buffered payload: {[illegal], mb,rw,md,mw,pl,jb,bc, op_select, rd, rsA, rsB}
    localparam int BASE_W = NUM_CTRL_BITS + OPSEL_W + 3 * RA_W;
    localparam int PAY_W  = BASE_W + ILL_W;
    localparam int P_RSA  = RA_W;
    localparam int P_RD   = 2 * RA_W;
    localparam int P_OPS  = 3 * RA_W;
    localparam int P_CTL  = 3 * RA_W + OPSEL_W;

    // Input-side decode
    logic [OPC_W-1:0]  opc_s;
    logic [RA_W-1:0]   rd_s;
    logic [RA_W-1:0]   rsa_s;
    logic [RA_W-1:0]   rsb_s;
    logic [2:0]        cls_s;
    ctrl_word_t        ctrl_s;
    logic [PAY_W-1:0]  pay_in_s;
    logic              is_load_s;
    logic              dep_s;
    logic              acc_s;
    logic              pop_s;
    logic              push_s;
    logic [PAY_W-1:0]  push_pay_s;
    logic [1:0]        cnt_after_s;

    // State
    logic [1:0]        cnt_q, cnt_d;
    logic [PAY_W-1:0]  ent0_q, ent0_d;
    logic [PAY_W-1:0]  ent1_q, ent1_d;
    logic              stg_valid_q, stg_valid_d;
    logic [PAY_W-1:0]  stg_q, stg_d;
    logic              hz_valid_q, hz_valid_d;
    logic [RA_W-1:0]   hz_tag_q, hz_tag_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
`ifdef DEC_ILLEGAL_TRAP_EN
    logic              ill_s;
    logic              trap_q, trap_d;
`endif

    assign opc_s = OPC_W'(fld_opcode(32'(instr), RA_W));
    assign rd_s  = RA_W'(fld_rd(32'(instr), RA_W));
    assign rsa_s = RA_W'(fld_rsa(32'(instr), RA_W));
    assign rsb_s = RA_W'(fld_rsb(32'(instr), RA_W));
    assign cls_s = opc_s[OPC_W-1 -: 3];

    dec_ctrl_lut #(
        .OPC_W   (OPC_W),
        .OPSEL_W (OPSEL_W)
    ) u_dec_ctrl_lut (
        .opcode (opc_s),
        .ctrl   (ctrl_s)
    );

`ifdef DEC_ILLEGAL_TRAP_EN
    assign ill_s = is_illegal_cls(cls_s);
`endif

    assign is_load_s = (cls_s == CLS_LD);
    assign dep_s     = hz_valid_q && ((rsa_s == hz_tag_q) || (rsb_s == hz_tag_q));
    assign acc_s     = in_valid && in_ready_q;
    assign pop_s     = out_valid_q && out_ready;

    // Pack the decoded instruction into the buffer payload format
    always_comb begin
        pay_in_s = '0;
        pay_in_s[BASE_W-1:0] = {ctrl_s.mb, ctrl_s.rw, ctrl_s.md, ctrl_s.mw,
                                ctrl_s.pl, ctrl_s.jb, ctrl_s.bc,
                                ctrl_s.op_select[OPSEL_W-1:0], rd_s, rsa_s, rsb_s};
`ifdef DEC_ILLEGAL_TRAP_EN
        pay_in_s[PAY_W-1] = ill_s;
`endif
    end

    // Next-state: flush, staging of dependent instructions, FIFO pop/push, hazard and trap tracking
    always_comb begin
        cnt_d       = cnt_q;
        ent0_d      = ent0_q;
        ent1_d      = ent1_q;
        stg_valid_d = stg_valid_q;
        stg_d       = stg_q;
        hz_valid_d  = hz_valid_q;
        hz_tag_d    = hz_tag_q;
        push_s      = 1'b0;
        push_pay_s  = '0;
        cnt_after_s = cnt_q;
`ifdef DEC_ILLEGAL_TRAP_EN
        trap_d      = trap_q;
`endif
        if (flush) begin
            // Kill everything held; any transfer on this edge is dropped
            cnt_d       = 2'd0;
            ent0_d      = '0;
            ent1_d      = '0;
            stg_valid_d = 1'b0;
            stg_d       = '0;
            hz_valid_d  = 1'b0;
            hz_tag_d    = '0;
`ifdef DEC_ILLEGAL_TRAP_EN
            trap_d      = 1'b0;
`endif
        end else begin
            // A staged instruction always enters the FIFO on the cycle after its bubble;
            // no input can be accepted then because in_ready is low.
            if (stg_valid_q) begin
                push_s      = 1'b1;
                push_pay_s  = stg_q;
                stg_valid_d = 1'b0;
                stg_d       = '0;
            end else if (acc_s && dep_s) begin
                stg_valid_d = 1'b1;
                stg_d       = pay_in_s;
            end else if (acc_s) begin
                push_s      = 1'b1;
                push_pay_s  = pay_in_s;
            end else begin
                push_s      = 1'b0;
            end

            // Only the instruction immediately after a load is checked against it
            if (acc_s) begin
                hz_valid_d = is_load_s;
                hz_tag_d   = is_load_s ? rd_s : '0;
            end else begin
                hz_valid_d = hz_valid_q;
            end

            // Pop shifts the skid entry into the head; empty slots stay zero
            if (pop_s) begin
                ent0_d      = ent1_q;
                ent1_d      = '0;
                cnt_after_s = cnt_q - 2'd1;
            end else begin
                cnt_after_s = cnt_q;
            end

            if (push_s && (cnt_after_s != 2'd2)) begin
                if (cnt_after_s == 2'd0) begin
                    ent0_d = push_pay_s;
                end else begin
                    ent1_d = push_pay_s;
                end
                cnt_d = cnt_after_s + 2'd1;
            end else begin
                cnt_d = cnt_after_s;
            end

`ifdef DEC_ILLEGAL_TRAP_EN
            if (acc_s && ill_s) begin
                trap_d = 1'b1;
            end else begin
                trap_d = trap_q;
            end
`endif
        end

        out_valid_d = (cnt_d != 2'd0);
`ifdef DEC_ILLEGAL_TRAP_EN
        in_ready_d  = (cnt_d < 2'd2) && !stg_valid_d && !trap_d;
`else
        in_ready_d  = (cnt_d < 2'd2) && !stg_valid_d;
`endif
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= 2'd0;
            ent0_q      <= '0;
            ent1_q      <= '0;
            stg_valid_q <= 1'b0;
            stg_q       <= '0;
            hz_valid_q  <= 1'b0;
            hz_tag_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef DEC_ILLEGAL_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            stg_valid_q <= stg_valid_d;
            stg_q       <= stg_d;
            hz_valid_q  <= hz_valid_d;
            hz_tag_q    <= hz_tag_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef DEC_ILLEGAL_TRAP_EN
            trap_q      <= trap_d;
`endif
        end
    end

    // Outputs come straight from the head entry flops
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign MB        = ent0_q[P_CTL+6];
    assign RW        = ent0_q[P_CTL+5];
    assign MD        = ent0_q[P_CTL+4];
    assign MW        = ent0_q[P_CTL+3];
    assign PL        = ent0_q[P_CTL+2];
    assign JB        = ent0_q[P_CTL+1];
    assign BC        = ent0_q[P_CTL];
    assign op_select = ent0_q[P_OPS +: OPSEL_W];
    assign rd        = ent0_q[P_RD +: RA_W];
    assign rsA       = ent0_q[P_RSA +: RA_W];
    assign rsB       = ent0_q[RA_W-1:0];
`ifdef DEC_ILLEGAL_TRAP_EN
    assign illegal   = ent0_q[PAY_W-1];
`endif

endmodule

// File: tb/tb_instr_dec_stage.sv
// Self-checking bench for instr_dec_stage (default parameters, 16-bit instr).
// Expected behaviour comes from a queue-based reference model driven by the
// decode table, the load-use rule and flush/reset rules. Honours DEC_ILLEGAL_TRAP_EN.
module tb_instr_dec_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        MB, RW, MD, MW, PL, JB, BC;
    logic [3:0]  op_select;
    logic [2:0]  rd, rsA, rsB;
`ifdef DEC_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [20:0] q[$];
    bit          pend;
    logic [20:0] pend_w;
    bit          hz_v;
    logic [2:0]  hz_tag;
    bit          trap;
    bit          rdy = 1'b1;

    instr_dec_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .MB        (MB),
        .RW        (RW),
        .MD        (MD),
        .MW        (MW),
        .PL        (PL),
        .JB        (JB),
        .BC        (BC),
        .op_select (op_select),
        .rd        (rd),
        .rsA       (rsA),
`ifdef DEC_ILLEGAL_TRAP_EN
        .rsB       (rsB),
        .illegal   (illegal)
`else
        .rsB       (rsB)
`endif
    );

    always #5 clk = ~clk;

    // Expected output word {illegal, MB,RW,MD,MW,PL,JB,BC, op_select, rd, rsA, rsB}
    function automatic logic [20:0] ref_dec(input logic [15:0] w);
        logic [2:0] cls;
        logic [6:0] c;
        logic       ill;
        cls = w[15:13];
        ill = 1'b0;
        c   = 7'b0;
        if (cls == 3'b000)      c = 7'b0100000;
        else if (cls == 3'b100) c = 7'b1100000;
        else if (cls == 3'b001) c = 7'b0110000;
        else if (cls == 3'b010) c = 7'b0001000;
        else if (cls == 3'b110) c = {6'b000010, w[9]};
        else if (cls == 3'b111) c = 7'b0000110;
        else begin
`ifdef DEC_ILLEGAL_TRAP_EN
            ill = 1'b1;
`endif
        end
        return {ill, c, w[12:9], w[8:6], w[5:3], w[2:0]};
    endfunction

    function automatic logic [20:0] obs();
`ifdef DEC_ILLEGAL_TRAP_EN
        return {illegal, MB, RW, MD, MW, PL, JB, BC, op_select, rd, rsA, rsB};
`else
        return {1'b0, MB, RW, MD, MW, PL, JB, BC, op_select, rd, rsA, rsB};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Advance the model by one clock edge using the values driven before it
    task automatic model_edge(input logic iv, input logic [15:0] w, input logic fl, input logic ordy);
        bit acc, pop, dep;
        logic [20:0] d;
        if (!rst_n) begin
            q.delete(); pend = 0; hz_v = 0; trap = 0; rdy = 1;
            return;
        end
        acc = iv && rdy;
        pop = (q.size() != 0) && ordy;
        if (fl) begin
            q.delete(); pend = 0; hz_v = 0; trap = 0;
        end else begin
            d   = ref_dec(w);
            dep = hz_v && ((w[5:3] == hz_tag) || (w[2:0] == hz_tag));
            if (pop) void'(q.pop_front());
            if (pend) begin
                q.push_back(pend_w);
                pend = 0;
            end else if (acc && dep) begin
                pend   = 1;
                pend_w = d;
            end else if (acc) begin
                q.push_back(d);
            end
            if (acc) begin
                hz_v   = (w[15:13] == 3'b001);
                hz_tag = w[8:6];
            end
`ifdef DEC_ILLEGAL_TRAP_EN
            if (acc && ((w[15:13] == 3'b011) || (w[15:13] == 3'b101))) trap = 1;
`endif
        end
        rdy = (q.size() < 2) && !pend && !trap;
    endtask

    // One cycle: drive, clock, update model, compare all outputs
    task automatic step(input logic iv, input logic [15:0] w, input logic fl, input logic ordy);
        in_valid  = iv;
        instr     = w;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        model_edge(iv, w, fl, ordy);
        #1;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("payload", 32'(obs()), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    endtask

    localparam logic [15:0] I_ALUI = 16'b100_0010_000_001_010;
    localparam logic [15:0] I_JMP  = 16'b111_0000_111_110_100;
    localparam logic [15:0] I_A    = 16'b000_0001_001_000_000;
    localparam logic [15:0] I_B    = 16'b000_0010_010_000_000;
    localparam logic [15:0] I_C    = 16'b000_0011_011_000_000;
    localparam logic [15:0] I_LD7  = 16'b001_0000_111_000_000;
    localparam logic [15:0] I_U7   = 16'b000_0001_001_111_000;
    localparam logic [15:0] I_U3   = 16'b000_0001_010_011_000;
    localparam logic [15:0] I_ILL  = 16'b101_0011_001_010_011;

    initial begin
        clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; instr = 16'd0; flush = 1'b0; out_ready = 1'b0;

        // Reset held for two cycles
        step(1'b0, 16'd0, 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b0, 1'b0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", 32'(obs()), 32'd0);
        rst_n = 1'b1;
        step(1'b0, 16'd0, 1'b0, 1'b1);

        // Decode: ALU immediate then jump
        step(1'b1, I_ALUI, 1'b0, 1'b1);
        chk("alui_ctrl", 32'({MB, RW, MD, MW, PL, JB, BC}), 32'b1100000);
        chk("alui_opsel", 32'(op_select), 32'b0010);
        chk("alui_regs", 32'({rd, rsA, rsB}), 32'b000_001_010);
        step(1'b1, I_JMP, 1'b0, 1'b1);
        chk("jmp_ctrl", 32'({MB, RW, MD, MW, PL, JB, BC}), 32'b0000110);
        chk("jmp_rsa", 32'(rsA), 32'd6);
        step(1'b0, 16'd0, 1'b0, 1'b1);

        // Backpressure: three pushes against a stalled datapath
        step(1'b1, I_A, 1'b0, 1'b0);
        step(1'b1, I_B, 1'b0, 1'b0);
        chk("bp_ready_drop", 32'(in_ready), 32'd0);
        step(1'b1, I_C, 1'b0, 1'b0);
        chk("bp_head_hold", 32'(rd), 32'd1);
        step(1'b1, I_C, 1'b0, 1'b1);
        chk("bp_second", 32'(rd), 32'd2);
        step(1'b1, I_C, 1'b0, 1'b1);
        chk("bp_third", 32'(rd), 32'd3);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Load-use with a dependent consumer: one bubble
        step(1'b1, I_LD7, 1'b0, 1'b1);
        step(1'b1, I_U7, 1'b0, 1'b1);
        chk("lu_bubble_valid", 32'(out_valid), 32'd0);
        chk("lu_bubble_ready", 32'(in_ready), 32'd0);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("lu_after_valid", 32'(out_valid), 32'd1);
        chk("lu_after_rd", 32'(rd), 32'd1);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        // Independent consumer: no bubble
        step(1'b1, I_LD7, 1'b0, 1'b1);
        step(1'b1, I_U3, 1'b0, 1'b1);
        chk("nolu_valid", 32'(out_valid), 32'd1);
        chk("nolu_rd", 32'(rd), 32'd2);
        step(1'b0, 16'd0, 1'b0, 1'b1);

        // Flush with two entries buffered and a simultaneous input
        step(1'b1, I_A, 1'b0, 1'b0);
        step(1'b1, I_B, 1'b0, 1'b0);
        step(1'b1, I_C, 1'b1, 1'b0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("flush_no_ghost", 32'(out_valid), 32'd0);
        // Flush while the input transfer really happens
        step(1'b1, I_A, 1'b0, 1'b0);
        step(1'b1, I_C, 1'b1, 1'b0);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("flush_drop_input", 32'(out_valid), 32'd0);

        // Illegal opcode class 101
        step(1'b1, I_ILL, 1'b0, 1'b1);
        chk("ill_ctrl", 32'({MB, RW, MD, MW, PL, JB, BC}), 32'd0);
        chk("ill_opsel", 32'(op_select), 32'b0011);
`ifdef DEC_ILLEGAL_TRAP_EN
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("trap_ready", 32'(in_ready), 32'd0);
        step(1'b1, I_A, 1'b0, 1'b1);
        step(1'b1, I_A, 1'b0, 1'b1);
        chk("trap_hold", 32'(in_ready), 32'd0);
        step(1'b0, 16'd0, 1'b1, 1'b1);
        chk("trap_cleared", 32'(in_ready), 32'd1);
`else
        chk("ill_stream_ready", 32'(in_ready), 32'd1);
        step(1'b1, I_A, 1'b0, 1'b1);
        chk("ill_stream_next", 32'(rd), 32'd1);
`endif
        step(1'b0, 16'd0, 1'b0, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            step($urandom_range(0, 3) != 0, w, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0);
        end

        // Mid-stream reset drops everything
        step(1'b1, I_A, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1'b1, I_B, 1'b0, 1'b0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("midrst_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
